// File: rtl/cpu_pkg.sv
// Types and constants shared by the core and its fetch-side blocks.
// Covers the PC geometry, the default confidence width and the predictor entry record.
package cpu_pkg;

    localparam int PC_W        = 16;
    localparam int INSN_BYTES  = 2;
    localparam int DEF_CTR_W   = 2;
    localparam int DEF_ENTRIES = 1024;
    localparam int DEF_TAG_W   = PC_W - $clog2(DEF_ENTRIES) - 1;

    typedef enum logic {
        BP_SWEEP = 1'b0,
        BP_READY = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
        logic [PC_W-1:0]      target;
        logic [DEF_CTR_W-1:0] ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_ram.sv
// Branch target storage: one async lookup port, a read-modify-write update port,
// and a per-entry valid-clear shared by the init sweep and store invalidates.
module btb_ram
    import cpu_pkg::*;
#(
    parameter  int ENTRIES = DEF_ENTRIES,
    parameter  int ADDR_W  = PC_W,
    parameter  int CTR_W   = DEF_CTR_W,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = ADDR_W - IDX_W - 1
) (
    input  logic              clk_i,

    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [ADDR_W-1:0] rd_target_o,
    output logic [CTR_W-1:0]  rd_ctr_o,

    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [ADDR_W-1:0] wr_target_i,
    input  logic              wr_taken_i,

    input  logic              clr_en_i,
    input  logic [IDX_W-1:0]  clr_idx_i,
    input  logic [TAG_W-1:0]  clr_tag_i,
    input  logic              clr_any_i
);

    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic wr_hit;
    logic clr_hit;

    function automatic logic [CTR_W-1:0] ctr_up(input logic [CTR_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_down(input logic [CTR_W-1:0] c);
        return (|c) ? c - 1'b1 : c;
    endfunction

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_ctr_o    = ctr_q[rd_idx_i];

    assign wr_hit  = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);
    assign clr_hit = clr_any_i || (tag_q[clr_idx_i] == clr_tag_i);

    // Payload fields are never reset; an entry is meaningless until valid is set.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            if (wr_hit) begin
                if (wr_taken_i) begin
                    ctr_q[wr_idx_i]    <= ctr_up(ctr_q[wr_idx_i]);
                    target_q[wr_idx_i] <= wr_target_i;
                end else begin
                    ctr_q[wr_idx_i]    <= ctr_down(ctr_q[wr_idx_i]);
                end
            end else if (wr_taken_i) begin
                tag_q[wr_idx_i]    <= wr_tag_i;
                target_q[wr_idx_i] <= wr_target_i;
                ctr_q[wr_idx_i]    <= CTR_WEAK;
            end
        end
    end

    // Clear is placed last so it overrides an allocation at the same index.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !wr_hit && wr_taken_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
        if (clr_en_i && clr_hit) begin
            valid_q[clr_idx_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor with saturating confidence counters.
// After reset or flush the table is swept clear one entry per cycle before going live.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ADDR_W  = PC_W,
    parameter int CTR_W   = DEF_CTR_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] lookup_pc,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              pred_hit,
    output logic              ready,

    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,

    input  logic              inv_valid,
    input  logic [ADDR_W-2:0] inv_addr,

    input  logic              flush_all
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             live;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [ADDR_W-1:0] rd_target;
    logic [CTR_W-1:0]  rd_ctr;
    logic [ADDR_W-1:0] seq_pc;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [IDX_W-1:0] inv_idx;
    logic [TAG_W-1:0] inv_tag;
    logic             upd_en;
    logic             inv_en;
    logic             collide;

    logic             wr_en;
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;
    logic             clr_any;
    logic             unused_upd_lsb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BP_SWEEP;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        live    = 1'b0;
        case (state_q)
            BP_SWEEP: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = BP_READY;
                end
            end
            BP_READY: begin
                live    = 1'b1;
                sweep_d = '0;
                if (flush_all) begin
                    state_d = BP_SWEEP;
                end
            end
            default: begin
                state_d = BP_SWEEP;
                sweep_d = '0;
            end
        endcase
    end

    assign lk_idx = lookup_pc[IDX_W:1];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
    assign seq_pc = lookup_pc + ADDR_W'(INSN_BYTES);

    assign ready    = live;
    assign pred_hit = live && rd_valid && (rd_tag == lk_tag);
    assign pred_pc  = (pred_hit && rd_ctr[CTR_W-1]) ? rd_target : seq_pc;

    assign upd_idx = upd_pc[IDX_W:1];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+1];
    assign inv_idx = inv_addr[IDX_W-1:0];
    assign inv_tag = inv_addr[ADDR_W-2:IDX_W];

    // A same-index invalidate suppresses the update and forces the entry invalid.
    assign upd_en  = live && upd_valid;
    assign inv_en  = live && inv_valid;
    assign collide = upd_en && inv_en && (upd_idx == inv_idx);

    assign wr_en   = upd_en && !collide;
    assign clr_en  = !live || inv_en;
    assign clr_idx = live ? inv_idx : sweep_q;
    assign clr_any = !live || collide;

    assign unused_upd_lsb = upd_pc[0];

    btb_ram #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .CTR_W   (CTR_W)
    ) u_btb_ram (
        .clk_i       (clk),
        .rd_idx_i    (lk_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_ctr_o    (rd_ctr),
        .wr_en_i     (wr_en),
        .wr_idx_i    (upd_idx),
        .wr_tag_i    (upd_tag),
        .wr_target_i (upd_target),
        .wr_taken_i  (upd_taken),
        .clr_en_i    (clr_en),
        .clr_idx_i   (clr_idx),
        .clr_tag_i   (inv_tag),
        .clr_any_i   (clr_any)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic checked
// against a table model built from the predictor's rules.
module tb_branch_predictor;

    localparam int ENT  = 1024;
    localparam int IW   = 10;
    localparam int CMAX = 3;
    localparam int CMSB = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] lookup_pc;
    logic [15:0] pred_pc;
    logic        pred_hit;
    logic        ready;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;
    logic        inv_valid;
    logic [14:0] inv_addr;
    logic        flush_all;

    int n_checks = 0;
    int n_err    = 0;

    bit m_valid [ENT];
    int m_tag   [ENT];
    int m_tgt   [ENT];
    int m_ctr   [ENT];
    bit m_ready = 1'b0;
    int m_sweep = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES (ENT),
        .ADDR_W  (16),
        .CTR_W   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_pc  (lookup_pc),
        .pred_pc    (pred_pc),
        .pred_hit   (pred_hit),
        .ready      (ready),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .flush_all  (flush_all)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_pred(input logic [15:0] pc, output bit hit, output logic [15:0] npc);
        int idx, tag;
        idx = (int'(pc) >> 1) % ENT;
        tag = int'(pc) >> (IW + 1);
        hit = m_ready && m_valid[idx] && (m_tag[idx] == tag);
        if (hit && m_ctr[idx] >= CMSB) npc = 16'(m_tgt[idx]);
        else                           npc = 16'((int'(pc) + 2) % 65536);
    endfunction

    task automatic model_edge();
        int ui, ut, ii, it;
        ui = (int'(upd_pc) >> 1) % ENT;
        ut = int'(upd_pc) >> (IW + 1);
        ii = int'(inv_addr) % ENT;
        it = int'(inv_addr) >> IW;
        if (!rst_n) begin
            m_ready = 1'b0;
            m_sweep = 0;
        end else if (!m_ready) begin
            m_valid[m_sweep] = 1'b0;
            if (m_sweep == ENT - 1) m_ready = 1'b1;
            m_sweep = (m_sweep + 1) % ENT;
        end else begin
            if (upd_valid && inv_valid && ui == ii) begin
                m_valid[ui] = 1'b0;
            end else begin
                if (upd_valid) begin
                    if (m_valid[ui] && m_tag[ui] == ut) begin
                        if (upd_taken) begin
                            m_ctr[ui] = (m_ctr[ui] < CMAX) ? m_ctr[ui] + 1 : CMAX;
                            m_tgt[ui] = int'(upd_target);
                        end else begin
                            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                        end
                    end else if (upd_taken) begin
                        m_valid[ui] = 1'b1;
                        m_tag[ui]   = ut;
                        m_tgt[ui]   = int'(upd_target);
                        m_ctr[ui]   = CMSB;
                    end
                end
                if (inv_valid && m_tag[ii] == it) m_valid[ii] = 1'b0;
            end
            if (flush_all) begin
                m_ready = 1'b0;
                m_sweep = 0;
            end
        end
    endtask

    // Compare outputs with the model before the edge, then advance both across it.
    task automatic cycle();
        bit          eh;
        logic [15:0] ep;
        #1;
        model_pred(lookup_pc, eh, ep);
        chk("ready", ready, m_ready);
        chk("pred_hit", pred_hit, eh);
        chk("pred_pc", pred_pc, ep);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_pc();
        int t, i;
        t = $urandom_range(0, 3);
        i = ($urandom_range(0, 9) == 0) ? ENT - 1 : $urandom_range(0, 7);
        return 16'((t << (IW + 1)) | (i << 1));
    endfunction

    task automatic idle_inputs();
        upd_valid = 1'b0;
        inv_valid = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic rand_inputs();
        logic [15:0] ipc;
        lookup_pc  = rand_pc();
        upd_valid  = 1'($urandom_range(0, 1));
        upd_pc     = rand_pc();
        upd_target = 16'($urandom) & 16'hFFFE;
        upd_taken  = ($urandom_range(0, 2) != 0);
        inv_valid  = ($urandom_range(0, 9) == 0);
        ipc        = rand_pc();
        inv_addr   = ipc[15:1];
        flush_all  = 1'b0;
    endtask

    task automatic sweep_wait(input string tag);
        for (int i = 0; i < ENT; i++) begin
            rand_inputs();
            lookup_pc = 16'($urandom);
            flush_all = 1'($urandom_range(0, 1));
            #1;
            chk({tag, "_ready_low"}, ready, 1'b0);
            cycle();
        end
        idle_inputs();
        #1;
        chk({tag, "_ready_high"}, ready, 1'b1);
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic [15:0] epc, input logic ehit);
        lookup_pc = pc;
        #1;
        chk({tag, "_pc"}, pred_pc, epc);
        chk({tag, "_hit"}, pred_hit, ehit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        lookup_pc  = 16'h0040;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
        inv_addr   = '0;
        idle_inputs();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();

        rst_n = 1'b1;
        sweep_wait("init");
        look("first_lookup", 16'h0040, 16'h0042, 1'b0);
        cycle();

        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0100;
        cycle();
        idle_inputs();
        look("alloc", 16'h0010, 16'h0100, 1'b1);
        upd_valid = 1'b1; upd_taken = 1'b0;
        cycle();
        idle_inputs();
        look("weaken", 16'h0010, 16'h0012, 1'b1);
        look("alias", 16'h0810, 16'h0812, 1'b0);
        cycle();

        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1; upd_target = 16'h0200;
        inv_valid = 1'b1; inv_addr = 15'h0008;
        cycle();
        idle_inputs();
        look("inv_wins", 16'h0010, 16'h0012, 1'b0);
        look("wrap", 16'hFFFE, 16'h0000, 1'b0);
        cycle();

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        idle_inputs();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                upd_valid  = 1'b1;
                upd_taken  = 1'b1;
                upd_pc     = 16'((t << (IW + 1)) | (i << 1));
                upd_target = 16'h4000 + 16'(i * 2);
                lookup_pc  = upd_pc;
                cycle();
            end
        end
        idle_inputs();
        look("pre_flush", 16'h1804, 16'h4004, 1'b1);
        flush_all = 1'b1;
        cycle();
        flush_all = 1'b0;
        sweep_wait("flush");
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                lookup_pc = 16'((t << (IW + 1)) | (i << 1));
                #1;
                chk("post_flush_hit", pred_hit, 1'b0);
                cycle();
            end
        end

        flush_all = 1'b1;
        cycle();
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            cycle();
        end
        rst_n = 1'b0;
        idle_inputs();
        cycle();
        rst_n = 1'b1;
        sweep_wait("rst_mid");

        for (int i = 0; i < 1000; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 1024: number of predictor entries; power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-002 Parameter ADDR_W, default 16: PC width in bits; instructions are 2-byte aligned.
REQ-003 Parameter CTR_W, default 2: width of the per-entry saturating confidence counter; at least 1.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 lookup_pc  input  ADDR_W  fetch PC to predict.
REQ-007 pred_pc  output  ADDR_W  predicted next PC, combinational from lookup_pc.
REQ-008 pred_hit  output  1  lookup_pc matched a valid entry.
REQ-009 ready  output  1  table initialised; predictions and updates are live.
REQ-010 upd_valid  input  1  qualifies a resolved-branch update this cycle.
REQ-011 upd_pc, upd_target  input  ADDR_W each  resolved branch PC and its actual target.
REQ-012 upd_taken  input  1  resolved branch was taken.
REQ-013 inv_valid  input  1  qualifies an invalidate request (store to code).
REQ-014 inv_addr  input  ADDR_W-1  halfword address of the stored word (PC bits [ADDR_W-1:1]).
REQ-015 flush_all  input  1  request to clear the whole table.

Function
REQ-016 Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+1], target (ADDR_W bits), ctr (CTR_W bits). Entry index = pc[IDX_W:1].
REQ-017 A lookup hits when ready=1, the entry at the index is valid, and the stored tag equals the lookup tag.
REQ-018 pred_pc = stored target when the lookup hits and the ctr MSB is 1; otherwise pred_pc = lookup_pc + 2, truncated to ADDR_W bits (wraps to 0).
REQ-019 Lookups read pre-edge table state. A write made at edge N becomes visible to lookups from cycle N+1 onward.
REQ-020 Update when upd_valid=1 and the update hits:
  - taken: ctr saturates upward at all-ones; target <= upd_target.
  - not taken: ctr saturates downward at 0; target unchanged.
REQ-021 Update when upd_valid=1 and the update misses:
  - taken: allocate (overwrite) the entry; valid=1, tag from upd_pc, target=upd_target, ctr = 1 followed by zeros (weakly taken).
  - not taken: no change.
REQ-022 When inv_valid=1, an entry whose index and tag match {inv_addr,1'b0} is cleared to valid=0. A non-matching entry is unchanged.
REQ-023 If an invalidate and an update target the same index in the same cycle, the invalidate wins and the entry ends with valid=0.
REQ-024 FSM states and transitions:
  - SWEEP: clears one entry per cycle, index counting 0 to ENTRIES-1; after clearing index ENTRIES-1, moves to READY at the next edge.
  - READY: flush_all=1 moves to SWEEP with the counter at 0.
REQ-025 In SWEEP: ready=0, pred_hit=0, pred_pc = lookup_pc + 2; upd_valid, inv_valid and flush_all are ignored.
REQ-026 ready=1 only in READY; it rises exactly ENTRIES cycles after a sweep starts.

Reset
REQ-027 rst_n=0 at an edge forces SWEEP with the sweep counter at 0; this applies in any state, including mid-sweep, which restarts from index 0.
REQ-028 During and after reset until READY, outputs are ready=0 and pred_hit=0, and pred_pc follows lookup_pc + 2. No output is ever X after the first reset edge.

Structure
REQ-029 The shared package cpu_pkg defines PC_W=16, INSN_BYTES=2, the default CTR_W, and the entry record type. The core and this block both import it.
REQ-030 The storage array is a single sub-module btb_ram: one asynchronous read port, one synchronous write port, and a per-entry valid-clear used by the sweep and by invalidates.

Verification (ENTRIES=1024, ADDR_W=16, CTR_W=2)
REQ-031 Release rst_n -> ready=0 for 1024 cycles, then 1. Lookup 0x0040 -> pred_pc=0x0042, pred_hit=0.
REQ-032 Update pc 0x0010, taken, target 0x0100 -> next cycle lookup 0x0010 gives 0x0100 with hit=1. Then one not-taken update -> lookup gives 0x0012 with hit=1.
REQ-033 After REQ-032's allocation, lookup 0x0810 (same index, different tag) -> pred_pc=0x0812, pred_hit=0.
REQ-034 Same cycle: taken update for 0x0010 and inv_addr=0x0008 -> next-cycle lookup 0x0010 gives 0x0012 with hit=0.
REQ-035 Lookup 0xFFFE on a miss -> pred_pc=0x0000.
REQ-036 Mid-operation checks:
  - flush_all in READY -> ready=0 for 1024 cycles, then all prior entries miss.
  - rst_n=0 at sweep cycle 500 -> ready rises 1024 cycles after rst_n returns high.
